// File: rtl/pulse_stretcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher_pkg
// Description : State encoding and dwell-counter width rule shared by the
//               pulse stretcher and its dwell counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_stretcher_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    // Width able to hold (dwell - 1) for the longer of the two dwells, never 0
    function automatic int dwell_w(input int high_cycles, input int low_cycles);
        int m;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage : pulse_stretcher_pkg
`default_nettype wire

// File: rtl/pulse_stretcher_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Loadable down-counter that stops at zero and flags it.
//               Shared by the HIGH and LOW dwell phases.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : dwell_counter
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher
// Description : Turns single-cycle tick strobes into level pulses of fixed
//               high width and minimum low gap. Ticks arriving mid-pulse are
//               queued in a saturating counter; overflow is flagged on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic level,
    output logic busy,
    output logic drop
);

    localparam int             CW          = dwell_w(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [CW-1:0]  C_HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]  C_LOW_LOAD  = CW'(LOW_CYCLES - 1);

    logic [1:0]        r_state;
    logic [PEND_W-1:0] r_pending;
    logic              r_level;
    logic              r_drop;

    logic [1:0]        w_next;
    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_zero;
    logic              w_queue;
    logic              w_consume;
    logic              w_pend_nz;
    logic              w_full;

    assign w_pend_nz = (r_pending != '0);
    assign w_full    = &r_pending;

    dwell_counter #(
        .WIDTH (CW)
    ) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Next-state, dwell reload and queue/consume decisions
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = C_HIGH_LOAD;
        w_queue    = 1'b0;
        w_consume  = 1'b0;
        case (r_state)
            IDLE: begin
                if (tick) begin
                    w_next     = HIGH;
                    w_load     = 1'b1;
                    w_load_val = C_HIGH_LOAD;
                end
            end
            HIGH: begin
                w_queue = tick;
                if (w_zero) begin
                    w_next     = LOW;
                    w_load     = 1'b1;
                    w_load_val = C_LOW_LOAD;
                end
            end
            LOW: begin
                if (w_zero) begin
                    if (w_pend_nz || tick) begin
                        // A queued tick is served first; a coincident new tick
                        // then takes its place in the queue
                        w_next     = HIGH;
                        w_load     = 1'b1;
                        w_load_val = C_HIGH_LOAD;
                        w_consume  = w_pend_nz;
                        w_queue    = w_pend_nz && tick;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    w_queue = tick;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, saturating pending counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_level   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_level <= (w_next == HIGH);
            r_drop  <= w_queue && !w_consume && w_full;
            if (w_queue && w_consume) begin
                r_pending <= r_pending;
            end else if (w_queue && !w_full) begin
                r_pending <= r_pending + PEND_W'(1);
            end else if (w_consume) begin
                r_pending <= r_pending - PEND_W'(1);
            end
        end
    end

    assign level = r_level;
    assign drop  = r_drop;
    assign busy  = (r_state != IDLE) || w_pend_nz;

endmodule : pulse_stretcher
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretcher
// Description : Self-checking bench for pulse_stretcher: table of 32-cycle
//               tick/expected-waveform vectors plus hand-written sequences for
//               asynchronous reset mid-pulse and the 1/1/1 saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tick, level, busy, drop;
    logic reset2, tick2, level2, busy2, drop2;

    pulse_stretcher dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .level (level),
        .busy  (busy),
        .drop  (drop)
    );

    pulse_stretcher #(
        .HIGH_CYCLES (1),
        .LOW_CYCLES  (1),
        .PEND_W      (1)
    ) dut_min (
        .clk   (clk),
        .reset (reset2),
        .tick  (tick2),
        .level (level2),
        .busy  (busy2),
        .drop  (drop2)
    );

    // Bit c of each field = value during cycle c after reset release
    typedef struct {
        logic [31:0] tick;
        logic [31:0] level;
        logic [31:0] busy;
        logic [31:0] drop;
    } vec_t;

    typedef struct {
        int         sel;
        int         cyc;
        logic [2:0] exp;
    } sb_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];
    sb_t  sb_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push_exp(input int sel, input int cyc,
                            input logic l, input logic b, input logic d);
        sb_t e;
        e.sel = sel;
        e.cyc = cyc;
        e.exp = {l, b, d};
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        sb_t        e;
        logic [2:0] act;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            e   = sb_q.pop_front();
            act = (e.sel != 0) ? {level2, busy2, drop2} : {level, busy, drop};
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s cycle %0d: {level,busy,drop} got %b expected %b",
                         tag, e.cyc, act, e.exp);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        tick   = 1'b0;
        tick2  = 1'b0;

        // single tick
        vecs[0] = '{tick: 32'h0000_0020, level: 32'h0000_03C0, busy: 32'h0000_0FC0, drop: 32'h0};
        // two consecutive ticks
        vecs[1] = '{tick: 32'h0000_0060, level: 32'h0000_F3C0, busy: 32'h0003_FFC0, drop: 32'h0};
        // five ticks: queue saturates, one drop, four pulses
        vecs[2] = '{tick: 32'h0000_03E0, level: 32'h0F3C_F3C0, busy: 32'h3FFF_FFC0, drop: 32'h0000_0400};
        // tick on final LOW cycle: direct re-entry, no queueing
        vecs[3] = '{tick: 32'h0000_0820, level: 32'h0000_F3C0, busy: 32'h0003_FFC0, drop: 32'h0};
        // two isolated ticks
        vecs[4] = '{tick: 32'h0010_0020, level: 32'h01E0_03C0, busy: 32'h07E0_0FC0, drop: 32'h0};
        // tick in the very first cycle
        vecs[5] = '{tick: 32'h0000_0001, level: 32'h0000_001E, busy: 32'h0000_007E, drop: 32'h0};
        // tick in first LOW cycle is queued and served at the end of LOW
        vecs[6] = '{tick: 32'h0000_0420, level: 32'h0000_F3C0, busy: 32'h0003_FFC0, drop: 32'h0};

        repeat (2) @(negedge clk);
        push_exp(0, -1, 1'b0, 1'b0, 1'b0);
        check_out("reset_state");
        push_exp(1, -1, 1'b0, 1'b0, 1'b0);
        check_out("reset_state_min");

        for (int v = 0; v < NVEC; v++) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 32; c++) begin
                push_exp(0, c, vecs[v].level[c], vecs[v].busy[c], vecs[v].drop[c]);
                tick = vecs[v].tick[c];
                check_out($sformatf("vec%0d", v));
                @(negedge clk);
            end
            tick = 1'b0;
        end

        // Asynchronous reset mid-pulse with one tick queued
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            push_exp(0, c,
                     (c == 6 || c == 7 || (c >= 11 && c <= 14)),
                     (c == 6 || c == 7 || (c >= 11 && c <= 16)),
                     1'b0);
            tick = (c == 5 || c == 6 || c == 10);
            check_out("reset_seq");
            if (c == 7) begin
                reset = 1'b1;
                #1;
                push_exp(0, c, 1'b0, 1'b0, 1'b0);
                check_out("async_reset");
            end
            if (c == 8) begin
                reset = 1'b0;
            end
            @(negedge clk);
        end
        tick = 1'b0;

        // Minimum dwell, single-entry queue, tick held high
        reset = 1'b1;
        reset2 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            push_exp(1, c, (c % 2 == 1), (c >= 1), (c >= 4 && c % 2 == 0));
            tick2 = 1'b1;
            check_out("min_cont");
            @(negedge clk);
        end
        tick2  = 1'b0;
        reset2 = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pulse_stretcher
`default_nettype wire

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle `tick` strobes into level pulses of guaranteed width, separated by a guaranteed low gap, so a slow or edge-detecting consumer sees exactly one rising edge per tick. It is the producing end of the tick/level interface: it turns ticks back into levels, and a downstream edge detector recovers one tick per pulse. Ticks that arrive while a pulse is in progress are queued in a saturating pending counter. Excess ticks are flagged as dropped, never silently lost.

## Interface
- `HIGH_CYCLES`, default 4: cycles `level` is held high per pulse. Must be ≥1.
- `LOW_CYCLES`, default 2: minimum cycles `level` is held low after each pulse. Must be ≥1.
- `PEND_W`, default 2: width of the pending-tick counter. Maximum queued ticks = 2^PEND_W−1.
- `clk` input 1: the single clock for the block.
- `reset` input 1: asynchronous, active-high.
- `tick` input 1: request strobe, sampled on every rising `clk`.
- `level` output 1: stretched pulse output, registered.
- `busy` output 1: high whenever the state is not IDLE or `pending` ≠ 0.
- `drop` output 1: one-cycle pulse, registered, meaning a tick was discarded because the queue was full.

## Operation
- States and their meaning:
  - IDLE: `level` = 0.
  - HIGH: `level` = 1. Dwell counter runs for HIGH_CYCLES.
  - LOW: `level` = 0. Dwell counter runs for LOW_CYCLES.
- Dwell counter:
  - Loaded with (dwell−1) on entry to each state.
  - Decrements every cycle.
  - The state is exited when the counter is 0.
- Transitions:
  - IDLE → HIGH when `tick` = 1.
  - HIGH → LOW when the HIGH dwell expires. This happens unconditionally.
  - LOW → HIGH when the LOW dwell expires and (`pending` ≠ 0 or `tick` = 1).
  - LOW → IDLE when the LOW dwell expires otherwise.
- Pending counter, updated each cycle:
  - +1 if `tick` is accepted for queueing.
  - −1 if it is consumed on a LOW→HIGH transition.
  - Both in the same cycle: net 0.
  - A tick that directly causes an IDLE→HIGH or LOW→HIGH transition is not queued.
- A tick is queued when it arrives in HIGH, or in LOW before the final LOW cycle.
- If a tick would be queued while `pending` = 2^PEND_W−1:
  - The tick is discarded.
  - `drop` is 1 in the following cycle.
  - `pending` is unchanged. It saturates and never wraps.
- At the final LOW cycle, with both `pending` ≠ 0 and `tick` = 1:
  - One pending tick is consumed.
  - The incoming tick is queued.
  - Net effect: `pending` is unchanged.
- Invalid state encoding → IDLE on the next edge.
- Reset values: state IDLE, `level` 0, `drop` 0, `pending` 0, dwell counter 0, and therefore `busy` 0.
- Reset asserted at any time, including mid-pulse:
  - `level` falls asynchronously.
  - The queue is cleared.
  - Queued ticks are not reported as dropped.

## Timing
- Latency: a tick sampled at the edge ending cycle k gives `level` = 1 in cycles k+1 … k+HIGH_CYCLES.
- After a pulse, `level` = 0 for at least LOW_CYCLES cycles.
- Minimum pulse period is HIGH_CYCLES+LOW_CYCLES. This is also the maximum sustained throughput.
- Back-to-back pulses have no extra IDLE cycle. HIGH is re-entered directly from the final LOW cycle.
- `busy` is combinational from registered state and `pending`, so it has no added latency.
- `drop` has one cycle of latency from the offending tick.
- No combinational path from `tick` to any output.

## Structure
- Shared include/package holds:
  - the state encoding localparams IDLE/HIGH/LOW (2 bits),
  - the dwell-counter width rule: clog2 of max(HIGH_CYCLES, LOW_CYCLES), minimum 1.
- One sub-module, `dwell_counter`:
  - parameterised down-counter with a load port and a `zero` flag.
  - Instantiated once and shared by the HIGH and LOW states.
- Top level contains:
  - a state register plus next-state/output logic,
  - the pending counter,
  - the registered `level`/`drop` outputs.

## Test plan
All scenarios use the defaults (4/2/2) unless stated otherwise.
- Single tick in cycle 5 → `level` high in cycles 6–9 and low from 10; `busy` clears in cycle 12; no `drop`.
- Ticks in cycles 5 and 6 → `level` high 6–9, low 10–11, high 12–15; two rising edges; `pending` peaks at 1.
- Ticks in cycles 5–9 (five ticks) → `pending` saturates at 3 after cycle 8; `drop` = 1 in cycle 10; exactly four pulses, starting at cycles 6, 12, 18 and 24.
- Single tick in cycle 5, then a tick in cycle 11 (final LOW cycle) → `level` high again at 12 with no IDLE gap; `pending` stays 0 throughout.
- Tick in cycle 5, reset pulsed mid-cycle 7 → `level` 0 immediately and `pending` 0; a tick in cycle 10 produces a normal pulse in cycles 11–14.
- HIGH_CYCLES=1, LOW_CYCLES=1, PEND_W=1, tick held high continuously → `level` alternates 1,0,1,0…; `drop` asserts every other cycle once the queue is full.
